// File: rtl/rc_req_initiator_pkg.sv
// Shared types and helpers for the rc_reqn/rc_ackn reconfiguration handshake.
// The handshake lines are active-low; use RC_ASSERT/RC_DEASSERT, not raw bits.
package rc_sync_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        BACKOFF = 2'd2,
        GRANT   = 2'd3
    } rc_state_e;

    localparam logic RC_ASSERT   = 1'b0;
    localparam logic RC_DEASSERT = 1'b1;

    // Timer width: the largest load value is max(...)-1, so $clog2(max) bits suffice.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic int att_width(input int max_retry);
        return $clog2(max_retry + 2);
    endfunction

endpackage

// File: rtl/rc_req_initiator_if.sv
// Handshake and status bundle between the requesting controller and the initiator.
interface rc_req_initiator_if
    import rc_sync_pkg::*;
#(
    parameter int MAX_RETRY = 3
) ();
    localparam int AW = att_width(MAX_RETRY);

    logic          start;
    logic          rc_ackn;
    logic          rc_reqn;
    logic          rc_grant;
    logic          busy;
    logic          done;
    logic          err;
    logic          stray_ack;
    logic          start_drop;
    logic [AW-1:0] attempt;

    modport master (
        input  start, rc_ackn,
        output rc_reqn, rc_grant, busy, done, err, stray_ack, start_drop, attempt
    );

    modport slave (
        output start, rc_ackn,
        input  rc_reqn, rc_grant, busy, done, err, stray_ack, start_drop, attempt
    );
endinterface

// File: rtl/rc_req_initiator_timer.sv
// Loadable down-counter shared by the REQ, BACKOFF and GRANT phases.
// Loaded with N-1 so expire marks the Nth cycle; it holds at zero rather than wrapping.
module rc_req_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);
    logic [W-1:0] value;

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign expire = (value == '0);
endmodule

// File: rtl/rc_req_initiator.sv
// Requesting side of the rc_reqn/rc_ackn handshake: bounded request with
// timeout/backoff/retry, then a fixed grant window; all outputs registered.
module rc_req_initiator
    import rc_sync_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRY      = 3,
    parameter int GRANT_CYCLES   = 16,
    parameter int GAP_CYCLES     = 4
) (
    input  logic                clk,
    input  logic                rst,
    rc_req_initiator_if.master  bus
);
    localparam int TW = cnt_width(TIMEOUT_CYCLES, GRANT_CYCLES, GAP_CYCLES);
    localparam int AW = att_width(MAX_RETRY);

    localparam logic [TW-1:0] LD_REQ   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] LD_GRANT = TW'(GRANT_CYCLES - 1);
    localparam logic [TW-1:0] LD_GAP   = TW'(GAP_CYCLES - 1);
    localparam logic [AW-1:0] ATT_MAX  = AW'(MAX_RETRY);

    rc_state_e     state, state_nx;
    logic [AW-1:0] attempt_q, attempt_nx;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_expire;
    logic          done_nx, err_nx;
    logic          ack_seen;

    logic reqn_q, grant_q, done_q, err_q, stray_q, drop_q;
    logic pending;
    logic ackn_q;

    assign ack_seen = (bus.rc_ackn == RC_ASSERT);

    rc_req_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_nx   = state;
        attempt_nx = attempt_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start || pending) begin
                    state_nx   = REQ;
                    attempt_nx = '0;
                    tmr_load   = 1'b1;
                    tmr_val    = LD_REQ;
                end
            end
            REQ: begin
                // Ack beats timeout when both land on the expiry cycle.
                if (ack_seen) begin
                    state_nx = GRANT;
                    tmr_load = 1'b1;
                    tmr_val  = LD_GRANT;
                end else if (tmr_expire) begin
                    if (attempt_q < ATT_MAX) begin
                        state_nx   = BACKOFF;
                        attempt_nx = attempt_q + AW'(1);
                        tmr_load   = 1'b1;
                        tmr_val    = LD_GAP;
                    end else begin
                        state_nx = IDLE;
                        err_nx   = 1'b1;
                    end
                end
            end
            BACKOFF: begin
                // A slow responder may still be answering the previous request.
                if (ack_seen) begin
                    state_nx = GRANT;
                    tmr_load = 1'b1;
                    tmr_val  = LD_GRANT;
                end else if (tmr_expire) begin
                    state_nx = REQ;
                    tmr_load = 1'b1;
                    tmr_val  = LD_REQ;
                end
            end
            GRANT: begin
                if (tmr_expire) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            attempt_q <= '0;
            reqn_q    <= RC_DEASSERT;
            grant_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            stray_q   <= 1'b0;
            drop_q    <= 1'b0;
            pending   <= 1'b0;
            ackn_q    <= RC_DEASSERT;
        end else begin
            state     <= state_nx;
            attempt_q <= attempt_nx;
            reqn_q    <= (state_nx == REQ) ? RC_ASSERT : RC_DEASSERT;
            grant_q   <= (state_nx == GRANT);
            done_q    <= done_nx;
            err_q     <= err_nx;
            ackn_q    <= bus.rc_ackn;
            // Only the leading cycle of an idle-time ack is reported.
            stray_q   <= (state == IDLE) && ack_seen && (ackn_q == RC_DEASSERT);
            drop_q    <= 1'b0;
            // IDLE always leaves when pending is set, so clearing it there is the consume.
            if (state == IDLE) begin
                pending <= 1'b0;
            end else if (bus.start) begin
                if (pending) drop_q  <= 1'b1;
                else         pending <= 1'b1;
            end
        end
    end

    assign bus.rc_reqn    = reqn_q;
    assign bus.rc_grant   = grant_q;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.stray_ack  = stray_q;
    assign bus.start_drop = drop_q;
    assign bus.attempt    = attempt_q;
endmodule
